// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, taken-branch flush, memory-wait freeze,
// registered EX operand-forward selects and saturating stall/flush counters
// for a 5-stage RV32I pipeline.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset2,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_taken,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic [1:0]       rs1_src,
    output logic [1:0]       rs2_src,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Tracking state for EX (e_*) and MEM (m_*) plus registered selects/counters
    logic [4:0]       e_rd_q, e_rd_d, m_rd_q, m_rd_d;
    logic             e_wr_q, e_wr_d, m_wr_q, m_wr_d;
    logic             e_ld_q, e_ld_d, m_ld_q, m_ld_d;
    logic [1:0]       rs1_src_q, rs1_src_d, rs2_src_q, rs2_src_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic writes, uses_rs1, uses_rs2, is_load;
    logic mem_wait, lu;

    // Saturating increment: holds at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Nearest producer wins; x0 and unused operands always read the register file
    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                           input logic [4:0] erd, input logic ewr,
                                           input logic [4:0] mrd, input logic mwr,
                                           input logic mld);
        if (!used || rs == 5'd0) return 2'd0;
        if (ewr && erd == rs)    return 2'd1;
        if (mwr && mrd == rs)    return mld ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    // Decode register usage of the ID instruction
    always_comb begin
        writes   = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_load  = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OPC_LOAD:   begin writes = 1'b1; uses_rs1 = 1'b1; is_load = 1'b1; end
                OPC_STORE,
                OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OPC_OPIMM,
                OPC_JALR:   begin writes = 1'b1; uses_rs1 = 1'b1; end
                OPC_OP:     begin writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OPC_LUI,
                OPC_AUIPC,
                OPC_JAL:    writes = 1'b1;
                default:    ;
            endcase
        end
    end

    assign mem_wait = m_ld_q & ~mem_ready;
    assign lu = id_valid & e_ld_q & (e_rd_q != 5'd0) &
                ((uses_rs1 & (id_rs1 == e_rd_q)) | (uses_rs2 & (id_rs2 == e_rd_q)));

    // Prioritised pipeline control and next-state for tracking, selects and counters
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;
        e_rd_d      = e_rd_q;
        e_wr_d      = e_wr_q;
        e_ld_d      = e_ld_q;
        m_rd_d      = m_rd_q;
        m_wr_d      = m_wr_q;
        m_ld_d      = m_ld_q;
        rs1_src_d   = rs1_src_q;
        rs2_src_d   = rs2_src_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset2) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            e_rd_d      = 5'd0;
            e_wr_d      = 1'b0;
            e_ld_d      = 1'b0;
            m_rd_d      = 5'd0;
            m_wr_d      = 1'b0;
            m_ld_d      = 1'b0;
            rs1_src_d   = 2'd0;
            rs2_src_d   = 2'd0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else if (mem_wait) begin
            // Freeze everything; a pending taken branch is held by EX until release
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            m_rd_d = e_rd_q;
            m_wr_d = e_wr_q;
            m_ld_d = e_ld_q;
            if (ex_taken || lu) begin
                // Flush outranks load-use: only the flush is counted
                idex_bubble = 1'b1;
                e_rd_d      = 5'd0;
                e_wr_d      = 1'b0;
                e_ld_d      = 1'b0;
                rs1_src_d   = 2'd0;
                rs2_src_d   = 2'd0;
                if (ex_taken) begin
                    ifid_flush  = 1'b1;
                    flush_cnt_d = sat_inc(flush_cnt_q);
                end else begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    stall_cnt_d = sat_inc(stall_cnt_q);
                end
            end else begin
                e_rd_d    = id_rd;
                e_wr_d    = writes;
                e_ld_d    = is_load;
                rs1_src_d = fwd_sel(uses_rs1, id_rs1, e_rd_q, e_wr_q, m_rd_q, m_wr_q, m_ld_q);
                rs2_src_d = fwd_sel(uses_rs2, id_rs2, e_rd_q, e_wr_q, m_rd_q, m_wr_q, m_ld_q);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        e_rd_q      <= e_rd_d;
        e_wr_q      <= e_wr_d;
        e_ld_q      <= e_ld_d;
        m_rd_q      <= m_rd_d;
        m_wr_q      <= m_wr_d;
        m_ld_q      <= m_ld_d;
        rs1_src_q   <= rs1_src_d;
        rs2_src_q   <= rs2_src_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign busy      = (lu | mem_wait) & ~reset2;
    assign rs1_src   = rs1_src_q;
    assign rs2_src   = rs2_src_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vector table, then random stimulus
// against an in-bench pipeline model. A CNT_W=2 copy exercises saturation.
module tb_hazard_controller;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
    localparam logic [6:0] OPI = 7'b0010011, OP = 7'b0110011, LUI = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;

    // ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we}
    localparam logic [5:0] NORM = 6'b110101, RST = 6'b001010, FRZ = 6'b000000;
    localparam logic [5:0] LU = 6'b000111, TKN = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset2, id_valid, ex_taken, mem_ready;
    logic [6:0] id_opcode;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, busy;
    logic [1:0] rs1_src, rs2_src;
    logic [15:0] stall_cnt, flush_cnt;
    logic s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_bubble, s_exmem_we, s_busy;
    logic [1:0] s_rs1_src, s_rs2_src, s_stall_cnt, s_flush_cnt;

    hazard_controller #(.CNT_W(16)) u_dut (
        .clk(clk), .reset2(reset2), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_taken(ex_taken),
        .mem_ready(mem_ready), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_we(exmem_we),
        .rs1_src(rs1_src), .rs2_src(rs2_src), .busy(busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    hazard_controller #(.CNT_W(2)) u_sat (
        .clk(clk), .reset2(reset2), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_taken(ex_taken),
        .mem_ready(mem_ready), .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
        .idex_we(s_idex_we), .idex_bubble(s_idex_bubble), .exmem_we(s_exmem_we),
        .rs1_src(s_rs1_src), .rs2_src(s_rs2_src), .busy(s_busy),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

    typedef struct { logic [5:0] ctl; int rs1; int rs2; bit busy; int st; int fl; } exp_t;
    typedef struct { bit rst; bit v; logic [6:0] op; int rd; int rs1; int rs2;
                     bit tk; bit rdy; exp_t e; } vec_t;
    typedef struct { int rd; bit wr; bit ld; } ins_t;

    int checks = 0;
    int errors = 0;

    // Model: pipe[0] is the instruction in EX, pipe[1] the one in MEM
    ins_t pipe[2];
    int md_rs1, md_rs2, md_st, md_fl;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic vec_t mk(input bit rst, input bit v, input logic [6:0] op,
                                input int rd, input int rs1, input int rs2,
                                input bit tk, input bit rdy, input logic [5:0] ctl,
                                input int r1, input int r2, input bit bsy,
                                input int st, input int fl);
        vec_t x;
        x.rst = rst; x.v = v; x.op = op; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
        x.tk = tk; x.rdy = rdy;
        x.e.ctl = ctl; x.e.rs1 = r1; x.e.rs2 = r2; x.e.busy = bsy; x.e.st = st; x.e.fl = fl;
        return x;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        reset2    = x.rst;
        id_valid  = x.v;
        id_opcode = x.op;
        id_rd     = 5'(x.rd);
        id_rs1    = 5'(x.rs1);
        id_rs2    = 5'(x.rs2);
        ex_taken  = x.tk;
        mem_ready = x.rdy;
    endtask

    task automatic compare(input exp_t e, input string tag);
        check({tag, " ctl"}, {26'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we},
              {26'd0, e.ctl});
        check({tag, " rs1_src"}, {30'd0, rs1_src}, e.rs1);
        check({tag, " rs2_src"}, {30'd0, rs2_src}, e.rs2);
        check({tag, " busy"}, {31'd0, busy}, {31'd0, e.busy});
        check({tag, " stall_cnt"}, {16'd0, stall_cnt}, sat(e.st, 65535));
        check({tag, " flush_cnt"}, {16'd0, flush_cnt}, sat(e.fl, 65535));
        check({tag, " sat stall_cnt"}, {30'd0, s_stall_cnt}, sat(e.st, 3));
        check({tag, " sat flush_cnt"}, {30'd0, s_flush_cnt}, sat(e.fl, 3));
    endtask

    function automatic void decode(input vec_t x, output bit wr, output bit u1,
                                   output bit u2, output bit ld);
        wr = x.v && (x.op inside {LOAD, OPI, OP, LUI, AUIPC, JAL, JALR});
        u1 = x.v && !(x.op inside {LUI, AUIPC, JAL});
        u2 = x.v && (x.op inside {OP, STORE, BRANCH});
        ld = x.v && (x.op == LOAD);
    endfunction

    function automatic int src_of(input bit used, input int rs);
        if (!used || rs == 0) return 0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].wr && pipe[k].rd == rs)
                return (k == 0) ? 1 : (pipe[k].ld ? 3 : 2);
        return 0;
    endfunction

    function automatic bit load_use(input vec_t x);
        bit wr, u1, u2, ld;
        decode(x, wr, u1, u2, ld);
        if (!pipe[0].ld) return 0;
        return (u1 && x.rs1 != 0 && x.rs1 == pipe[0].rd) ||
               (u2 && x.rs2 != 0 && x.rs2 == pipe[0].rd);
    endfunction

    function automatic exp_t model_expect(input vec_t x);
        exp_t e;
        bit mw, l;
        mw = pipe[1].ld && !x.rdy;
        l  = load_use(x);
        e.rs1 = md_rs1; e.rs2 = md_rs2; e.st = md_st; e.fl = md_fl;
        if (x.rst)      begin e.ctl = RST;  e.busy = 0; end
        else if (mw)    begin e.ctl = FRZ;  e.busy = 1; end
        else if (x.tk)  begin e.ctl = TKN;  e.busy = l; end
        else if (l)     begin e.ctl = LU;   e.busy = 1; end
        else            begin e.ctl = NORM; e.busy = 0; end
        return e;
    endfunction

    function automatic void model_update(input vec_t x);
        bit wr, u1, u2, ld, l;
        ins_t empty, nw;
        empty = '{rd: 0, wr: 0, ld: 0};
        decode(x, wr, u1, u2, ld);
        l = load_use(x);
        if (x.rst) begin
            pipe[0] = empty; pipe[1] = empty;
            md_rs1 = 0; md_rs2 = 0; md_st = 0; md_fl = 0;
        end else if (pipe[1].ld && !x.rdy) begin
            md_st = sat(md_st + 1, 65535);
        end else if (x.tk || l) begin
            if (x.tk) md_fl = sat(md_fl + 1, 65535);
            else      md_st = sat(md_st + 1, 65535);
            pipe[1] = pipe[0]; pipe[0] = empty;
            md_rs1 = 0; md_rs2 = 0;
        end else begin
            md_rs1 = src_of(u1, x.rs1);
            md_rs2 = src_of(u2, x.rs2);
            nw = '{rd: x.rd, wr: wr, ld: ld};
            pipe[1] = pipe[0]; pipe[0] = nw;
        end
    endfunction

    vec_t tbl[$];
    logic [6:0] ops[9];

    initial begin
        vec_t x;
        ops = '{LOAD, STORE, BRANCH, OPI, OP, LUI, AUIPC, JAL, JALR};

        //              rst v op     rd rs1 rs2 tk rdy ctl  r1 r2 busy st fl
        tbl.push_back(mk(1, 0, OPI,    0, 0, 0,  0, 1, RST,  0, 0, 0, 0, 0)); // reset state
        tbl.push_back(mk(0, 1, OPI,    5, 0, 0,  0, 1, NORM, 0, 0, 0, 0, 0)); // addi x5
        tbl.push_back(mk(0, 1, OP,     6, 5, 5,  0, 1, NORM, 0, 0, 0, 0, 0)); // add x6,x5,x5
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 1, NORM, 1, 1, 0, 0, 0)); // add in EX
        tbl.push_back(mk(0, 1, OPI,    5, 0, 0,  0, 1, NORM, 0, 0, 0, 0, 0)); // addi x5
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 1, NORM, 0, 0, 0, 0, 0)); // nop
        tbl.push_back(mk(0, 1, OP,     7, 5, 0,  0, 1, NORM, 0, 0, 0, 0, 0)); // sub x7,x5,x0
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 1, NORM, 2, 0, 0, 0, 0)); // sub in EX
        tbl.push_back(mk(0, 1, LOAD,   3, 1, 0,  0, 1, NORM, 0, 0, 0, 0, 0)); // lw x3
        tbl.push_back(mk(0, 1, OP,     4, 3, 1,  0, 1, LU,   0, 0, 1, 0, 0)); // load-use bubble
        tbl.push_back(mk(0, 1, OP,     4, 3, 1,  0, 1, NORM, 0, 0, 0, 1, 0)); // consumer advances
        tbl.push_back(mk(0, 1, OPI,   12, 0, 0,  0, 1, NORM, 3, 0, 0, 1, 0)); // load data fwd
        tbl.push_back(mk(0, 1, LOAD,   8, 0, 0,  0, 1, NORM, 0, 0, 0, 1, 0)); // lw x8
        tbl.push_back(mk(0, 1, OP,     9,12,12,  0, 1, NORM, 0, 0, 0, 1, 0)); // add x9,x12,x12
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 0, FRZ,  2, 2, 1, 1, 0)); // wait 1
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 0, FRZ,  2, 2, 1, 2, 0)); // wait 2
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 0, FRZ,  2, 2, 1, 3, 0)); // wait 3
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 1, NORM, 2, 2, 0, 4, 0)); // release
        tbl.push_back(mk(0, 1, LOAD,   3, 0, 0,  0, 1, NORM, 0, 0, 0, 4, 0)); // lw x3
        tbl.push_back(mk(0, 1, OP,     4, 3, 1,  1, 1, TKN,  0, 0, 1, 4, 0)); // taken + lu
        tbl.push_back(mk(0, 0, OPI,    0, 0, 0,  0, 1, NORM, 0, 0, 0, 4, 1)); // after flush
        tbl.push_back(mk(0, 1, LOAD,   5, 0, 0,  0, 1, NORM, 0, 0, 0, 4, 1)); // lw x5
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 1, NORM, 0, 0, 0, 4, 1)); // nop
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  1, 0, FRZ,  0, 0, 1, 4, 1)); // wait beats taken
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  1, 1, TKN,  0, 0, 0, 5, 1)); // flush on release
        tbl.push_back(mk(0, 1, LOAD,   6, 0, 0,  0, 1, NORM, 0, 0, 0, 5, 2)); // lw x6
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 1, NORM, 0, 0, 0, 5, 2)); // nop
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 0, FRZ,  0, 0, 1, 5, 2)); // wait
        tbl.push_back(mk(1, 1, OPI,    0, 0, 0,  0, 0, RST,  0, 0, 0, 6, 2)); // reset mid-wait
        tbl.push_back(mk(0, 1, OPI,    0, 0, 0,  0, 0, NORM, 0, 0, 0, 0, 0)); // cleared

        x = mk(1, 0, OPI, 0, 0, 0, 0, 1, RST, 0, 0, 0, 0, 0);
        apply(x);
        model_update(x);
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            #2;
            compare(tbl[i].e, $sformatf("vec%0d", i));
            model_update(tbl[i]);
            @(posedge clk);
            #1;
        end

        for (int n = 0; n < 400; n++) begin
            x.rst = ($urandom_range(0, 39) == 0);
            x.v   = ($urandom_range(0, 7) != 0);
            x.op  = ops[$urandom_range(0, 8)];
            x.rd  = $urandom_range(0, 7);
            x.rs1 = $urandom_range(0, 7);
            x.rs2 = $urandom_range(0, 7);
            x.tk  = ($urandom_range(0, 5) == 0);
            x.rdy = ($urandom_range(0, 3) != 0);
            apply(x);
            #2;
            compare(model_expect(x), $sformatf("rnd%0d", n));
            model_update(x);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It tracks the destination registers of the instructions in EX and MEM and produces the per-stage write-enable, flush and bubble controls for the pipeline registers. It generates the registered rs1/rs2 operand-source selects consumed by the EX-stage operand muxes. It handles four cases: load-use stalls, taken-branch/jump flushes, multicycle data-memory waits, and saturating stall/flush performance counters.

## Interface
- CNT_W, 16, width of the stall and flush counters

- clk  in  1  core clock
- reset2  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  7  opcode of the ID instruction
- id_rd, id_rs1, id_rs2  in  5 each  register fields of the ID instruction
- ex_taken  in  1  branch/JAL/JALR resolved taken in EX this cycle
- mem_ready  in  1  data memory has completed the access of the load in MEM
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID register loads a NOP
- idex_we  out  1  ID/EX register enable
- idex_bubble  out  1  ID/EX register loads a NOP
- exmem_we  out  1  EX/MEM and MEM/WB register enable
- rs1_src, rs2_src  out  2 each  EX operand source: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB ALU result, 3 = MEM/WB load data
- busy  out  1  stall (load-use or memory wait) this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

## Operation
- **Decode of id_opcode**
  - writes = LOAD 0000011, OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - uses_rs1 = every valid opcode except LUI, AUIPC, JAL.
  - uses_rs2 = OP, STORE 0100011, BRANCH 1100011.
  - is_load = LOAD.
  - All four are forced 0 when id_valid = 0.
- **Tracking registers**
  - {e_rd, e_wr, e_ld} describe the instruction in EX; {m_rd, m_wr, m_ld} describe the instruction in MEM.
  - An entry with rd = 0 is never a forwarding or hazard source; x0 is never forwarded.
- **Combinational conditions**
  - mem_wait = m_ld & !mem_ready.
  - lu = id_valid & e_ld & e_rd≠0 & ((uses_rs1 & id_rs1==e_rd) | (uses_rs2 & id_rs2==e_rd)).
- **Priority each cycle** (highest first):
  - reset2: all *_we = 0, ifid_flush = 1, idex_bubble = 1.
  - mem_wait: all *_we = 0, flush = 0, bubble = 0. Whole pipe and tracking registers hold. rs*_src hold.
  - ex_taken: pc_we = ifid_we = idex_we = exmem_we = 1, ifid_flush = 1, idex_bubble = 1. m ← e, e ← empty.
  - lu: pc_we = ifid_we = 0, idex_we = exmem_we = 1, idex_bubble = 1. m ← e, e ← empty.
  - normal: all *_we = 1, flush = bubble = 0. m ← e, e ← {id_rd, writes, is_load}.
- **Forward select**, computed per operand against the ID instruction and registered on any cycle in which ID/EX advances:
  - Match e_wr & e_rd==rs → 1.
  - Else match m_wr & m_rd==rs → 3 if m_ld, else 2.
  - Else 0.
  - Operand unused → 0.
  - Bubble cycle (ex_taken or lu) → rs*_src ← 0.
- **Counters**
  - stall_cnt increments on every cycle with lu or mem_wait.
  - flush_cnt increments on every cycle with ex_taken and not mem_wait.
  - Both saturate at 2^CNT_W − 1.
- busy = (lu | mem_wait) & !reset2.

## Timing
- Reset values (registered): e_* = m_* = 0, rs1_src = rs2_src = 0, stall_cnt = flush_cnt = 0.
- Control outputs (*_we, flush, bubble, busy) are combinational from the current-cycle inputs and tracking registers, with zero latency.
- rs*_src are registered. They are updated at the edge where the instruction moves ID→EX and are valid throughout that instruction's EX cycle.
- Load-use costs exactly one bubble. On the next cycle the load sits in MEM and e is empty, so lu deasserts and the consumer gets source 3.
- ex_taken together with lu in the same cycle: the flush wins; no stall is counted.
- mem_wait together with ex_taken: the freeze wins and ex_taken must be held by EX until release. The flush is counted once, on the release cycle.
- reset2 asserted mid-stall or mid-wait clears all state at the next edge. Normal operation resumes on the first cycle after deassertion.

## Test plan
- **ALU back-to-back:** addi x5 then add x6,x5,x5.
  - rs1_src = rs2_src = 1 in the add's EX; no busy.
- **Distance 2:** addi x5, nop, sub x7,x5,x0.
  - rs1_src = 2, rs2_src = 0 (x0).
- **Load-use:** lw x3, then add x4,x3,x1.
  - One cycle with pc_we = 0, idex_bubble = 1, busy = 1; then rs1_src = 3; stall_cnt = 1.
- **Memory wait:** lw in MEM with mem_ready low for 3 cycles.
  - All *_we = 0 for 3 cycles; rs*_src unchanged; stall_cnt += 3.
- **Taken branch with simultaneous load-use pattern:** ex_taken = 1 while ID holds a load consumer.
  - ifid_flush = idex_bubble = 1, pc_we = 1, flush_cnt = 1, stall_cnt unchanged.
- **Counter saturation and reset:** CNT_W = 2, 5 stall cycles.
  - stall_cnt stays at 3; reset2 mid-wait → all counters and selects are 0 on the next cycle.
